// File: rtl/mdl_reg_ctrl.sv
// mdl_reg_ctrl: host bus write controller in front of the LFO block.
// Synchronises host strobes, decodes register writes and applies each data write on a phi1 edge.
module mdl_reg_ctrl #(
  parameter int BUSY_CYCLES = 64,
  parameter int SYNC_STAGES = 2
) (
  input  logic       i_EMUCLK,
  input  logic       i_MRST_n,
  input  logic       i_phi1_NCEN_n,
  input  logic       i_CS_n,
  input  logic       i_WR_n,
  input  logic       i_A0,
  input  logic [7:0] i_D,
  output logic       o_BUSY,
  output logic [7:0] o_LFRQ,
  output logic [6:0] o_AMD,
  output logic [6:0] o_PMD,
  output logic [1:0] o_W,
  output logic [1:0] o_CT,
  output logic [7:0] o_TEST,
  output logic       o_LFRQ_UPDATE_n
);

  localparam int CNT_W = 7;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BUSY_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = 7'd0;
  localparam logic [CNT_W-1:0] CNT_ONE  = 7'd1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PEND = 2'd1,
    ST_BUSY = 2'd2
  } state_t;

  logic                   wr_s;
  logic                   ncen_s;
  logic                   commit_s;
  logic [SYNC_STAGES-1:0] sync_r;
  logic                   sync_d_r;
  logic                   a0_r;
  logic [7:0]             d_r;
  logic [7:0]             addr_r;
  state_t                 state_r;
  logic [CNT_W-1:0]       cnt_r;
  logic [7:0]             pend_addr_r;
  logic [7:0]             pend_data_r;
  logic                   busy_r;
  logic                   upd_n_r;
  logic [7:0]             lfrq_r;
  logic [6:0]             amd_r;
  logic [6:0]             pmd_r;
  logic [1:0]             w_r;
  logic [1:0]             ct_r;
  logic [7:0]             test_r;

  assign wr_s     = ~i_CS_n & ~i_WR_n;
  assign ncen_s   = ~i_phi1_NCEN_n;
  // A write is committed once the synchronised strobe has fallen, so A0/D are long settled.
  assign commit_s = sync_d_r & ~sync_r[SYNC_STAGES-1];

  // Strobe synchroniser plus capture of A0/D while the host strobe is asserted
  always_ff @(posedge i_EMUCLK or negedge i_MRST_n) begin
    if (!i_MRST_n) begin
      sync_r   <= {SYNC_STAGES{1'b0}};
      sync_d_r <= 1'b0;
      a0_r     <= 1'b0;
      d_r      <= 8'h00;
    end else begin
      sync_r   <= {sync_r[SYNC_STAGES-2:0], wr_s};
      sync_d_r <= sync_r[SYNC_STAGES-1];
      if (wr_s) begin
        a0_r <= i_A0;
        d_r  <= i_D;
      end
    end
  end

  // Address latch; address writes are taken even while a data write is in flight
  always_ff @(posedge i_EMUCLK or negedge i_MRST_n) begin
    if (!i_MRST_n) begin
      addr_r <= 8'h00;
    end else if (commit_s && !a0_r) begin
      addr_r <= d_r;
    end
  end

  // Write scheduler: hold a data write until phi1, apply it, then keep BUSY for the hold-off period
  always_ff @(posedge i_EMUCLK or negedge i_MRST_n) begin
    if (!i_MRST_n) begin
      state_r     <= ST_IDLE;
      cnt_r       <= CNT_ZERO;
      pend_addr_r <= 8'h00;
      pend_data_r <= 8'h00;
      busy_r      <= 1'b0;
      upd_n_r     <= 1'b1;
      lfrq_r      <= 8'h00;
      amd_r       <= 7'h00;
      pmd_r       <= 7'h00;
      w_r         <= 2'b00;
      ct_r        <= 2'b00;
      test_r      <= 8'h00;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (commit_s && a0_r) begin
            pend_addr_r <= addr_r;
            pend_data_r <= d_r;
            state_r     <= ST_PEND;
            busy_r      <= 1'b1;
          end
        end
        ST_PEND: begin
          if (ncen_s) begin
            cnt_r   <= CNT_LOAD;
            state_r <= ST_BUSY;
            case (pend_addr_r)
              8'h01: test_r <= pend_data_r;
              8'h18: begin
                lfrq_r  <= pend_data_r;
                upd_n_r <= 1'b0;
              end
              8'h19: begin
                if (pend_data_r[7]) pmd_r <= pend_data_r[6:0];
                else                amd_r <= pend_data_r[6:0];
              end
              8'h1B: begin
                w_r  <= pend_data_r[1:0];
                ct_r <= pend_data_r[7:6];
              end
              default: upd_n_r <= 1'b1;
            endcase
          end
        end
        ST_BUSY: begin
          if (ncen_s) begin
            upd_n_r <= 1'b1;
            if (cnt_r == CNT_ZERO) begin
              state_r <= ST_IDLE;
              busy_r  <= 1'b0;
            end else begin
              cnt_r <= cnt_r - CNT_ONE;
            end
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          upd_n_r <= 1'b1;
        end
      endcase
    end
  end

  assign o_BUSY          = busy_r;
  assign o_LFRQ          = lfrq_r;
  assign o_AMD           = amd_r;
  assign o_PMD           = pmd_r;
  assign o_W             = w_r;
  assign o_CT            = ct_r;
  assign o_TEST          = test_r;
  assign o_LFRQ_UPDATE_n = upd_n_r;

endmodule
